// File: rtl/hp0_ring_writer_pkg.sv
// Shared constants and types for the HP0 ring writer.
package hp0_ring_writer_pkg;

  // Address width of the PS wrapper HP0 slave port.
  localparam int HP0_ADDR_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/hp0_ring_writer_sync_fifo.sv
// Single-clock show-ahead FIFO: head always presents the oldest word,
// a push becomes visible (empty low / level up) one cycle later.
module hp0_ring_writer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_idx];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  // Read/write indices wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_idx <= '0;
      rd_idx <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + 1'b1;
      if (do_pop)  rd_idx <= rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hp0_ring_writer.sv
// Streams 32-bit words into a DDR ring buffer through single-beat AXI4-lite
// writes on HP0. Addresses are ring-relative byte offsets; wr_ptr counts
// only writes whose bresp has come back.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no write outstanding; applies pending ptr_clr, else starts
//           | a write when FIFO non-empty and enable high
//   ST_XFER | AW and W offered independently until both have handshaked
//   ST_RESP | bready high, waiting for bvalid; pointer advances on it
module hp0_ring_writer
  import hp0_ring_writer_pkg::*;
#(
  parameter int ADDR_W     = HP0_ADDR_W,
  parameter int FIFO_DEPTH = 16,
  parameter int RING_WORDS = 1024,
  localparam int PTR_W = $clog2(RING_WORDS),
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              ptr_clr,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              err_resp,
  output logic              busy
);

  wr_state_e   state;
  wr_state_e   state_nxt;
  logic        rst_done;
  logic        push;
  logic        pop;
  logic [31:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        aw_pend;
  logic        w_pend;
  logic [31:0] hold_data;
  logic        clr_pend;
  logic        clr_req;
  logic        xfer_done;
  logic        unused_rd;

  // The read channel is never used; its inputs are deliberately ignored.
  assign unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};

  assign s_ready = rst_done & ~fifo_full;
  assign push    = s_valid & s_ready;

  hp0_ring_writer_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // A clear requested this cycle or left over from a transaction blocks issue.
  assign clr_req   = ptr_clr | clr_pend;
  assign xfer_done = (~aw_pend | m_axi_awready) & (~w_pend | m_axi_wready);

  // Holds s_ready and rready low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; the FIFO pop doubles as the transaction start strobe.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!clr_req && !fifo_empty && enable) begin
          state_nxt = ST_XFER;
          pop       = 1'b1;
        end
      end
      ST_XFER: begin
        if (xfer_done) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (m_axi_bvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // AW/W valid flags and the held data word; each valid drops after its own handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      hold_data <= '0;
    end else if (pop) begin
      aw_pend   <= 1'b1;
      w_pend    <= 1'b1;
      hold_data <= fifo_head;
    end else begin
      if (m_axi_awready) aw_pend <= 1'b0;
      if (m_axi_wready)  w_pend  <= 1'b0;
    end
  end

  // Ring pointer, sticky error flag and deferred pointer-clear request.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      err_resp <= 1'b0;
      clr_pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (clr_req) begin
        wr_ptr   <= '0;
        err_resp <= 1'b0;
        clr_pend <= 1'b0;
      end
    end else begin
      if (ptr_clr) clr_pend <= 1'b1;
      if (state == ST_RESP && m_axi_bvalid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (m_axi_bresp != AXI_RESP_OKAY) err_resp <= 1'b1;
      end
    end
  end

  assign m_axi_awaddr  = ADDR_W'({wr_ptr, 2'b00});
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = aw_pend;
  assign m_axi_wdata   = hold_data;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = w_pend;
  assign m_axi_bready  = (state == ST_RESP);

  assign m_axi_araddr  = '0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = rst_done;

  assign busy = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_hp0_ring_writer.sv
// Bench for hp0_ring_writer: randomised AXI slave plus a queue-based model of
// what the block must emit, compared every cycle at the falling edge.
module tb_hp0_ring_writer;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int RING_WORDS = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        enable = 1'b0;
  logic        ptr_clr = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [2:0]  wr_ptr;
  logic [4:0]  fifo_level;
  logic        err_resp;
  logic        busy;

  always #5 aclk = ~aclk;

  hp0_ring_writer #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RING_WORDS (RING_WORDS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .ptr_clr       (ptr_clr),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .wr_ptr        (wr_ptr),
    .fifo_level    (fifo_level),
    .err_resp      (err_resp),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: words waiting to be written, and the one in flight.
  logic [31:0] q_words[$];
  int          m_ptr;
  bit          m_err, m_pend, m_out, m_aw_open, m_w_open, m_resp, m_oor;
  logic [31:0] m_addr, m_word;
  int          n_started;
  int          max_level;
  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];

  // Slave behaviour knobs and state.
  int   ready_pct = 100;
  int   aw_hold = 0, w_hold = 0;
  int   b_min = 0, b_max = 0;
  int   err_idx = -1;
  int   txn_idx = 0;
  int   aw_seen, w_seen, b_cnt;
  bit   sl_aw_got, sl_w_got;
  logic nxt_awready, nxt_wready, nxt_bvalid;
  logic [1:0] nxt_bresp;

  // Slave outputs move just after the rising edge.
  always @(posedge aclk) begin
    #1;
    m_axi_awready = nxt_awready;
    m_axi_wready  = nxt_wready;
    m_axi_bvalid  = nxt_bvalid;
    m_axi_bresp   = nxt_bresp;
  end

  // Compare, then advance the model and slave by what the next rising edge will do.
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
      chk("rst_wr_ptr", wr_ptr, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_err_busy", {err_resp, busy}, 0);
      q_words.delete();
      m_ptr = 0; m_err = 0; m_pend = 0; m_out = 0;
      m_aw_open = 0; m_w_open = 0; m_resp = 0; m_oor = 0;
      sl_aw_got = 0; sl_w_got = 0; aw_seen = 0; w_seen = 0; b_cnt = 0;
      nxt_awready = 0; nxt_wready = 0; nxt_bvalid = 0; nxt_bresp = 0;
    end else begin
      chk("s_ready", s_ready, m_oor && (q_words.size() < FIFO_DEPTH));
      chk("fifo_level", fifo_level, q_words.size());
      chk("busy", busy, (q_words.size() > 0) || m_out);
      chk("wr_ptr", wr_ptr, m_ptr);
      chk("err_resp", err_resp, m_err);
      chk("awvalid", m_axi_awvalid, m_aw_open);
      chk("wvalid", m_axi_wvalid, m_w_open);
      chk("bready", m_axi_bready, m_resp);
      chk("read_chan", {m_axi_arvalid, m_axi_arprot, m_axi_araddr[27:0]}, 0);
      chk("rready", m_axi_rready, m_oor);
      if (m_aw_open) begin
        chk("awaddr", m_axi_awaddr, m_addr);
        chk("awprot", m_axi_awprot, 0);
      end
      if (m_w_open) begin
        chk("wdata", m_axi_wdata, m_word);
        chk("wstrb", m_axi_wstrb, 4'hF);
      end
      if (fifo_level > max_level) max_level = fifo_level;
      if (m_axi_awvalid && m_axi_awready) addr_log.push_back(m_axi_awaddr);
      if (m_axi_wvalid && m_axi_wready)   data_log.push_back(m_axi_wdata);

      if (!m_out) begin
        if (ptr_clr || m_pend) begin
          m_ptr = 0; m_err = 0; m_pend = 0;
        end else if (enable && q_words.size() > 0) begin
          m_word = q_words.pop_front();
          m_addr = m_ptr * 4;
          m_out = 1; m_aw_open = 1; m_w_open = 1;
          n_started++;
        end
      end else begin
        if (ptr_clr) m_pend = 1;
        if (m_resp) begin
          if (m_axi_bvalid) begin
            m_ptr = (m_ptr + 1) % RING_WORDS;
            if (m_axi_bresp != 2'b00) m_err = 1;
            m_out = 0; m_resp = 0;
          end
        end else begin
          if (m_aw_open && m_axi_awready) m_aw_open = 0;
          if (m_w_open && m_axi_wready)   m_w_open = 0;
          if (!m_aw_open && !m_w_open) m_resp = 1;
        end
      end
      if (s_valid && s_ready) q_words.push_back(s_data);
      m_oor = 1;

      if (m_axi_awvalid && m_axi_awready) begin
        sl_aw_got = 1; aw_seen = 0; b_cnt = $urandom_range(b_max, b_min);
      end else if (m_axi_awvalid) aw_seen++;
      if (m_axi_wvalid && m_axi_wready) begin
        sl_w_got = 1; w_seen = 0;
      end else if (m_axi_wvalid) w_seen++;
      if (m_axi_bvalid && m_axi_bready) begin
        nxt_bvalid = 0; nxt_bresp = 0; txn_idx++;
      end else if (sl_aw_got && sl_w_got && !m_axi_bvalid) begin
        if (b_cnt == 0) begin
          nxt_bvalid = 1;
          nxt_bresp  = (txn_idx == err_idx) ? 2'b10 : 2'b00;
          sl_aw_got = 0; sl_w_got = 0;
        end else b_cnt--;
      end
      nxt_awready = (aw_seen >= aw_hold) && ($urandom_range(99) < ready_pct);
      nxt_wready  = (w_seen >= w_hold) && ($urandom_range(99) < ready_pct);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    int guard = 0;
    s_data = d;
    s_valid = 1'b1;
    @(negedge aclk);
    while (!s_ready && guard < 2000) begin
      guard++;
      @(negedge aclk);
    end
    if (guard >= 2000) chk("push_timeout", 0, 1);
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || q_words.size() != 0 || m_out) && g < 5000) begin
      cycles(1);
      g++;
    end
    chk("idle_timeout", g < 5000, 1);
    cycles(2);
  endtask

  task automatic pulse_clr();
    ptr_clr = 1'b1;
    cycles(1);
    ptr_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int g;
    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    cycles(2);
    enable = 1'b1;

    // Zero-wait slave, three words.
    push_word(32'hA0); push_word(32'hA1); push_word(32'hA2);
    wait_idle();
    chk("t1_wr_ptr", wr_ptr, 3);
    chk("t1_addr0", addr_log[0], 32'h0);
    chk("t1_addr1", addr_log[1], 32'h4);
    chk("t1_addr2", addr_log[2], 32'h8);
    chk("t1_data0", data_log[0], 32'hA0);
    chk("t1_data2", data_log[2], 32'hA2);
    chk("t1_busy", busy, 0);

    // AW stalled, then W stalled.
    aw_hold = 5;
    push_word($urandom);
    wait_idle();
    chk("t2_wr_ptr_aw", wr_ptr, 4);
    aw_hold = 0; w_hold = 5;
    push_word($urandom);
    wait_idle();
    chk("t2_wr_ptr_w", wr_ptr, 5);
    chk("t2_log_len", addr_log.size(), 5);
    w_hold = 0;

    // Five more words: words 9 and 10 wrap to the ring start.
    for (int i = 0; i < 5; i++) push_word($urandom);
    wait_idle();
    chk("t3_addr8", addr_log[8], 32'h0);
    chk("t3_addr9", addr_log[9], 32'h4);
    chk("t3_wr_ptr", wr_ptr, 2);

    // Slow bresp, 20 back-to-back words must fill the FIFO without loss.
    b_min = 10; b_max = 10; max_level = 0;
    for (int i = 0; i < 20; i++) push_word(32'h1000 + i);
    wait_idle();
    chk("t4_max_level", max_level, 16);
    chk("t4_wr_ptr", wr_ptr, 6);
    chk("t4_last_data", data_log[29], 32'h1000 + 19);
    b_min = 0; b_max = 0;

    // Error response on the second write, clears in IDLE.
    pulse_clr();
    cycles(1);
    chk("t5_clr_ptr", wr_ptr, 0);
    err_idx = txn_idx + 1;
    for (int i = 0; i < 3; i++) push_word($urandom);
    wait_idle();
    chk("t5_err", err_resp, 1);
    chk("t5_wr_ptr", wr_ptr, 3);
    err_idx = -1;
    pulse_clr();
    cycles(1);
    chk("t5_clr2_ptr", wr_ptr, 0);
    chk("t5_clr2_err", err_resp, 0);

    // Held off by enable, then a clear landing in RESP of the second write.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hC0 + i);
    cycles(10);
    chk("t6_level_held", fifo_level, 4);
    base = n_started;
    b_min = 3; b_max = 3;
    enable = 1'b1;
    g = 0;
    @(negedge aclk);
    while (!(m_axi_bready && n_started == base + 2) && g < 500) begin
      g++;
      @(negedge aclk);
    end
    chk("t6_resp_timeout", g < 500, 1);
    @(posedge aclk);
    #1;
    pulse_clr();
    wait_idle();
    chk("t6_addr_after_clr", addr_log[base + 2], 32'h0);
    chk("t6_addr_next", addr_log[base + 3], 32'h4);
    chk("t6_wr_ptr", wr_ptr, 2);

    // Random traffic, handshake timing, enable and clears.
    ready_pct = 70; b_min = 0; b_max = 3;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) == 0) pulse_clr();
      enable = ($urandom_range(4) != 0) || (fifo_level >= 5'd15);
      cycles($urandom_range(2));
      push_word($urandom);
    end
    enable = 1'b1;
    wait_idle();
    chk("rand_drained", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
